// File: rtl/char_draw_scheduler.sv
// Two-requester round-robin glyph scheduler: fetches 8x8 font rows from a
// registered ROM and streams 64 pixel writes per character to the VGA port.
module char_draw_scheduler #(
  parameter int unsigned CHAR_COLS = 20,
  parameter int unsigned CHAR_ROWS = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [6:0] char0,
  input  logic [4:0] col0,
  input  logic [3:0] row0,
  input  logic [2:0] colour0,
  input  logic       req1,
  input  logic [6:0] char1,
  input  logic [4:0] col1,
  input  logic [3:0] row1,
  input  logic [2:0] colour1,
  output logic       ack0,
  output logic       ack1,
  output logic [9:0] font_addr,
  input  logic [7:0] font_data,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, FINISH} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [6:0] char_q, char_d;
  logic [4:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic [2:0] fg_q, fg_d;
  logic [7:0] row_buf_q, row_buf_d;
  logic [5:0] cnt_q, cnt_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       grant0, grant1;
  logic       out_of_range;

  assign out_of_range = ({1'b0, col_q} >= 6'(CHAR_COLS)) ||
                        ({1'b0, row_q} >= 5'(CHAR_ROWS));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    char_d       = char_q;
    col_d        = col_q;
    row_d        = row_q;
    fg_d         = fg_q;
    row_buf_d    = row_buf_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    grant0       = 1'b0;
    grant1       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the requester other than the previous winner is served.
        grant1 = req1 & (~req0 | ~last_grant_q);
        grant0 = req0 & ~grant1;
        if (grant0 || grant1) begin
          last_grant_d = grant1;
          char_d       = grant1 ? char1   : char0;
          col_d        = grant1 ? col1    : col0;
          row_d        = grant1 ? row1    : row0;
          fg_d         = grant1 ? colour1 : colour0;
          state_d      = FETCH;
        end
      end
      FETCH:  state_d = out_of_range ? FINISH : LATCH;
      LATCH: begin
        row_buf_d = font_data;
        state_d   = DRAW;
      end
      DRAW: begin
        plot_d   = 1'b1;
        x_d      = {col_q, cnt_q[2:0]};
        y_d      = {row_q, cnt_q[5:3]};
        colour_d = row_buf_q[3'd7 - cnt_q[2:0]] ? fg_q : '0;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q[2:0] == 3'd7)
          state_d = (cnt_q[5:3] == 3'd7) ? FINISH : FETCH;
      end
      FINISH: begin
        done_d  = 1'b1;
        err_d   = out_of_range;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ack0_d = grant0;
    ack1_d = grant1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      char_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      fg_q         <= '0;
      row_buf_q    <= '0;
      cnt_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      char_q       <= char_d;
      col_q        <= col_d;
      row_q        <= row_d;
      fg_q         <= fg_d;
      row_buf_q    <= row_buf_d;
      cnt_q        <= cnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign font_addr = {char_q, cnt_q[5:3]};
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_char_draw_scheduler.sv
// Bench for char_draw_scheduler: directed scenarios plus random requests,
// checked against a cell-level model of the expected pixel stream.
module tb_char_draw_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [6:0] f_ch  [2];
  logic [4:0] f_col [2];
  logic [3:0] f_row [2];
  logic [2:0] f_fg  [2];
  logic       ack0, ack1, plot, busy, done, err;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic [7:0] x_w;
  logic [6:0] y_w;
  logic [2:0] colour_w;
  logic [7:0] font_mem [1024];

  int vectors = 0;
  int miscompares = 0;
  int model_last = 1;
  int last_x, last_y, nz_cnt;

  char_draw_scheduler #(.CHAR_COLS(20), .CHAR_ROWS(15)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .char0(f_ch[0]), .col0(f_col[0]), .row0(f_row[0]), .colour0(f_fg[0]),
    .req1(req1), .char1(f_ch[1]), .col1(f_col[1]), .row1(f_row[1]), .colour1(f_fg[1]),
    .ack0(ack0), .ack1(ack1), .font_addr(font_addr), .font_data(font_data),
    .x(x_w), .y(y_w), .colour(colour_w), .plot(plot), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // Registered font ROM: data valid the cycle after the address.
  always @(posedge clock) font_data <= font_mem[font_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_font(input int mode);
    for (int i = 0; i < 1024; i++)
      font_mem[i] = (mode == 0) ? 8'hF0 : (mode == 1) ? 8'h81 : 8'($urandom_range(0, 255));
  endtask

  task automatic set_fields(input int n, input int max_col, input int max_row);
    f_ch[n]  = 7'($urandom_range(0, 127));
    f_col[n] = 5'($urandom_range(0, max_col));
    f_row[n] = 4'($urandom_range(0, max_row));
    f_fg[n]  = 3'($urandom_range(1, 7));
  endtask

  // Predicts the winner from the request levels, then follows one character
  // from its ack to its done pulse, comparing every plotted pixel.
  task automatic run_char(input bit hold, output int ack_wait);
    int who, plots, busy_n, extra_ack, stray_err, done_at, g, p, exp_v;
    logic [6:0] ch;
    logic [4:0] col;
    logic [3:0] row;
    logic [2:0] fg;
    logic [7:0] fr;
    logic [9:0] fa1, fa2, fa3;
    bit oor, got, seen_err;

    who = (req0 && req1) ? 1 - model_last : (req1 ? 1 : 0);
    model_last = who;
    ch = f_ch[who]; col = f_col[who]; row = f_row[who]; fg = f_fg[who];
    oor = (int'(col) >= 20) || (int'(row) >= 15);

    got = 1'b0;
    ack_wait = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clock);
      ack_wait = i;
      if (ack0 || ack1) got = 1'b1;
    end
    check("ack_seen", got, 1);
    check("ack_pair", {ack1, ack0}, (who == 1) ? 2 : 1);
    if (!hold) begin
      if (who == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end

    busy_n = busy ? 1 : 0;
    fa1 = font_addr; fa2 = '0; fa3 = '0;
    plots = 0; extra_ack = 0; stray_err = 0; done_at = -1; seen_err = 1'b0;
    nz_cnt = 0; last_x = -1; last_y = -1;
    for (int t = 1; t <= 200 && done_at < 0; t++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (ack0 || ack1) extra_ack++;
      if (err && !done) stray_err++;
      if (plot) begin
        if (plots < 64) begin
          g = plots / 8;
          p = plots % 8;
          fr = font_mem[{ch, g[2:0]}];
          exp_v = ((int'(col) * 8 + p) << 10) | ((int'(row) * 8 + g) << 3) |
                  (fr[7 - p] ? int'(fg) : 0);
          check("plot_xyc", {14'b0, x_w, y_w, colour_w}, exp_v);
          if (p == 0) check("font_addr", fa3, {ch, g[2:0]});
        end
        if (colour_w != 3'b000) nz_cnt++;
        last_x = int'(x_w);
        last_y = int'(y_w);
        plots++;
      end
      if (done) begin
        done_at = t;
        seen_err = err;
      end
      fa3 = fa2; fa2 = fa1; fa1 = font_addr;
    end
    check("done_latency", done_at, oor ? 2 : 81);
    check("plot_count", plots, oor ? 0 : 64);
    check("busy_cycles", busy_n, oor ? 2 : 81);
    check("err_with_done", seen_err, oor);
    check("extra_ack", extra_ack, 0);
    check("stray_err", stray_err, 0);
  endtask

  initial begin
    int w, pc;
    for (int n = 0; n < 2; n++) begin
      f_ch[n] = '0; f_col[n] = '0; f_row[n] = '0; f_fg[n] = '0;
    end
    fill_font(0);

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_state", {plot, busy, done, err, ack0, ack1}, 0);
    check("rst_pixel", {x_w, y_w, colour_w}, 0);
    check("rst_font_addr", font_addr, 0);
    reset = 1'b0;
    model_last = 1;

    // Single requester, 'A' at cell (2,3), glyph rows 8'hF0
    f_ch[0] = 7'h41; f_col[0] = 5'd2; f_row[0] = 4'd3; f_fg[0] = 3'b010;
    req0 = 1'b1;
    run_char(1'b0, w);
    check("a_last_x", last_x, 23);
    check("a_last_y", last_y, 31);
    check("a_nonzero_px", nz_cnt, 32);

    // Out-of-range column
    f_ch[1] = 7'h20; f_col[1] = 5'd20; f_row[1] = 4'd1; f_fg[1] = 3'b111;
    req1 = 1'b1;
    run_char(1'b0, w);

    // Continuous tie: grants alternate
    fill_font(2);
    set_fields(0, 19, 14);
    set_fields(1, 19, 14);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_char(1'b1, w);
      if (k > 0) check("alt_gap", w, 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clock);

    // Bottom-right boundary cell, glyph 8'h81
    fill_font(1);
    f_ch[0] = 7'h5A; f_col[0] = 5'd19; f_row[0] = 4'd14; f_fg[0] = 3'b101;
    req0 = 1'b1;
    run_char(1'b0, w);
    check("bnd_last_x", last_x, 159);
    check("bnd_last_y", last_y, 119);
    check("bnd_nonzero_px", nz_cnt, 16);

    // Request held through done; fields change before the second grant edge
    fill_font(2);
    set_fields(0, 19, 14);
    req0 = 1'b1;
    run_char(1'b1, w);
    set_fields(0, 19, 14);
    run_char(1'b0, w);
    check("reack_gap", w, 1);

    // Reset on the 30th plot cycle
    set_fields(0, 19, 14);
    req0 = 1'b1;
    pc = 0;
    for (int i = 0; i < 120 && pc < 30; i++) begin
      @(negedge clock);
      if (ack0) req0 = 1'b0;
      if (plot) pc++;
    end
    check("rst_reach_30", pc, 30);
    reset = 1'b1;
    req0 = 1'b0;
    @(negedge clock);
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outs", {x_w, y_w, colour_w, done, err, ack0, ack1}, 0);
    check("mid_rst_font_addr", font_addr, 0);
    reset = 1'b0;
    model_last = 1;
    @(negedge clock);
    check("post_rst_plot", plot, 0);

    // First tie after reset, then the remaining requester
    set_fields(0, 19, 14);
    set_fields(1, 19, 14);
    req0 = 1'b1; req1 = 1'b1;
    run_char(1'b0, w);
    run_char(1'b0, w);

    // Random traffic, occasionally out of range
    for (int i = 0; i < 6; i++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin set_fields(0, 22, 15); req0 = 1'b1; end
      if (!req1 && $urandom_range(0, 1) == 1) begin set_fields(1, 22, 15); req1 = 1'b1; end
      if (!req0 && !req1) begin set_fields(0, 22, 15); req0 = 1'b1; end
      run_char(1'b0, w);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clock);
    check("final_idle", {busy, plot}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
